// File: rtl/sysref_distributor.sv
// Purpose : synchronise PL SYSREF, gate it by mode (off/continuous/one-shot), fan out per channel with delay/enable, monitor period.
// Latency : SYNC_STAGES + 2 + ch_delay[i] master_clock edges from pl_sysref to user_sysref[i].
// Backpressure: none; SYSREF is a free-running strobe, every cycle is sampled and forwarded.
module sysref_distributor #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DELAY_W     = 4,
  parameter int PERIOD_W    = 16,
  parameter int LOCK_N      = 4
) (
  input  logic                        master_clock,
  input  logic                        rst_n,
  input  logic                        pl_sysref,
  input  logic [1:0]                  mode,
  input  logic                        arm,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic [NUM_CH*DELAY_W-1:0]   ch_delay,
  input  logic                        err_clr,
  output logic [NUM_CH-1:0]           user_sysref,
  output logic                        armed,
  output logic [PERIOD_W-1:0]         sysref_period,
  output logic                        period_valid,
  output logic                        locked,
  output logic                        period_err
);

  localparam int DEPTH   = 2 ** DELAY_W;
  localparam int MATCH_W = $clog2(LOCK_N + 1);
  localparam logic [MATCH_W-1:0] LOCK_CNT = MATCH_W'(LOCK_N);

  typedef enum logic [1:0] {IDLE, ARMED, PASS, DONE} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   s;
  logic                   prev;
  logic                   primed;
  logic                   rise;
  logic                   g;
  state_t                 state;
  logic [DEPTH-1:0]       shreg;
  logic [PERIOD_W-1:0]    cnt;
  logic                   cnt_sat;
  logic                   started;
  logic [MATCH_W-1:0]     match;
  logic [MATCH_W-1:0]     match_nxt;
  logic                   err_set;

  assign s = sync_q[SYNC_STAGES-1];

  // A level still high when reset releases must not count as an edge:
  // primed only sets once the filled synchroniser has shown a low.
  assign rise = s & ~prev & primed;

  // Synchroniser, edge-detect history and post-reset priming.
  always_ff @(posedge master_clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
      prev   <= 1'b0;
      primed <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pl_sysref};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev   <= s;
      if (fill_q[SYNC_STAGES-1] && !s) primed <= 1'b1;
    end
  end

  // Mode gate; one-shot passes from the qualifying edge to the end of that pulse.
  always_comb begin
    g = 1'b0;
    case (mode)
      2'd1: g = s & primed;
      2'd2: begin
        if (state == ARMED)     g = rise;
        else if (state == PASS) g = s & primed;
        else                    g = 1'b0;
      end
      default: g = 1'b0;
    endcase
  end

  // One-shot FSM with registered armed flag.
  always_ff @(posedge master_clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else if (mode != 2'd2) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state <= ARMED;
            armed <= 1'b1;
          end
        end
        ARMED: begin
          if (rise) begin
            state <= PASS;
            armed <= 1'b0;
          end
        end
        PASS: begin
          if (!s) state <= DONE;
        end
        default: begin
          state <= IDLE;
          armed <= 1'b0;
        end
      endcase
    end
  end

  // Shared delay line; each channel taps its own stage.
  always_ff @(posedge master_clock or negedge rst_n) begin
    if (!rst_n) shreg <= '0;
    else        shreg <= {shreg[DEPTH-2:0], g};
  end

  // Per-channel registered output with enable.
  always_ff @(posedge master_clock or negedge rst_n) begin
    if (!rst_n) begin
      user_sysref <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        user_sysref[i] <= ch_enable[i] & shreg[ch_delay[i*DELAY_W +: DELAY_W]];
      end
    end
  end

  assign cnt_sat = &cnt;

  // Saturating match increment and sticky-error set condition.
  always_comb begin
    match_nxt = (match == LOCK_CNT) ? LOCK_CNT : match + 1'b1;
    err_set   = 1'b0;
    if (rise && started && period_valid) begin
      if (cnt_sat)                     err_set = 1'b1;
      else if (cnt != sysref_period)   err_set = 1'b1;
    end
  end

  // Period counter, measurement, lock tracking and sticky error.
  always_ff @(posedge master_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      started       <= 1'b0;
      match         <= '0;
      sysref_period <= '0;
      period_valid  <= 1'b0;
      locked        <= 1'b0;
      period_err    <= 1'b0;
    end else begin
      if (rise)          cnt <= {{(PERIOD_W-1){1'b0}}, 1'b1};
      else if (!cnt_sat) cnt <= cnt + 1'b1;

      if (rise) begin
        if (!started) begin
          // First edge after reset only opens the measurement window.
          started <= 1'b1;
        end else if (cnt_sat) begin
          locked <= 1'b0;
          match  <= '0;
        end else if (!period_valid) begin
          sysref_period <= cnt;
          period_valid  <= 1'b1;
        end else if (cnt == sysref_period) begin
          match  <= match_nxt;
          locked <= (match_nxt == LOCK_CNT);
        end else begin
          sysref_period <= cnt;
          match         <= '0;
          locked        <= 1'b0;
        end
      end

      if (err_set)      period_err <= 1'b1;
      else if (err_clr) period_err <= 1'b0;
    end
  end

endmodule
